// File: rtl/tile_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the nibble-addressed tile
// memory port. Port 0 is the game engine, port 1 the display/scan logic.
// One nibble read or write is in flight at a time; the winner's command is
// latched so the tile port sees a stable address and data for the whole
// transaction. A bounded WAIT keeps a hung tile port from stalling both
// requesters.
module tile_mem_arbiter #(
    parameter int depth   = 19,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [depth+2:0] r0_addr,
    input  logic [3:0]       r0_wdata,
    output logic             r0_gnt,
    output logic             r0_done,

    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [depth+2:0] r1_addr,
    input  logic [3:0]       r1_wdata,
    output logic             r1_gnt,
    output logic             r1_done,

    output logic [3:0]       rdata,
    output logic             timeout_err,
    output logic             busy,

    output logic             mem_write_en,
    output logic             mem_clean_mark,
    output logic [depth+2:0] mem_address,
    output logic [3:0]       mem_data_in,
    input  logic [3:0]       mem_data_out,
    input  logic             mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [depth+2:0] addr_q, addr_d;
    logic [3:0]       wdata_q, wdata_d;
    logic [3:0]       rdata_q, rdata_d;
    logic [9:0]       cnt_q, cnt_d;

    // Requester inputs gathered into vectors so the winner can be indexed.
    logic [1:0]       req_v;
    logic [1:0]       we_v;
    logic [depth+2:0] addr_v [2];
    logic [3:0]       wdata_v [2];
    logic [1:0]       gnt_v;
    logic [1:0]       done_v;
    logic             winner;
    logic             owns;

    assign req_v      = {r1_req, r0_req};
    assign we_v       = {r1_we, r0_we};
    assign addr_v[0]  = r0_addr;
    assign addr_v[1]  = r1_addr;
    assign wdata_v[0] = r0_wdata;
    assign wdata_v[1] = r1_wdata;

    // On a tie the port that was not served last wins; otherwise the sole requester.
    assign winner = (req_v[0] && req_v[1]) ? ~last_grant_q : req_v[1];

    // The selected port owns the memory from ISSUE through DONE.
    assign owns = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DONE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_v[gi]  = owns && (sel_q == 1'(gi));
        assign done_v[gi] = (state_q == S_DONE) && (sel_q == 1'(gi));
    end

    assign r0_gnt         = gnt_v[0];
    assign r1_gnt         = gnt_v[1];
    assign r0_done        = done_v[0];
    assign r1_done        = done_v[1];
    assign timeout_err    = (state_q == S_DONE) && err_q;
    assign busy           = (state_q != S_IDLE);
    assign mem_write_en   = (state_q == S_ISSUE) && we_q;
    assign mem_clean_mark = (state_q == S_ISSUE) && !we_q;
    assign mem_address    = addr_q;
    assign mem_data_in    = wdata_q;
    assign rdata          = rdata_q;

    // State register plus latched command, read data, grant history and timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic: arbitrate, issue one strobe, wait for ready or timeout, then drain.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req_v) begin
                    sel_d   = winner;
                    we_d    = we_v[winner];
                    addr_d  = addr_v[winner];
                    wdata_d = wdata_v[winner];
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 10'd1;
                // A ready arriving on the last allowed cycle still counts as success.
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_data_out;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_grant_d = sel_q;
                state_d      = S_DRAIN;
            end
            S_DRAIN: begin
                // Swallow the second ready cycle before a new command may go out.
                if (!mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
